// File: rtl/spu_calc_element_multi.sv
// Multi-lane opcode-driven INT calc element: product low half plus ADD/SUB/MAX/MIN/MAC result.
// Optional macro SPU_CALC_SAT_EN: saturate the DATA_BITS reduction of ADD/SUB/MAC results.
module spu_calc_element_multi #(
    parameter int LANES     = 4,
    parameter int DATA_BITS = 8,
    parameter int ACC_BITS  = 2*DATA_BITS+8,
    parameter int LATENCY   = 3
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       cke,
    input  logic [LANES*DATA_BITS-1:0] s_data0,
    input  logic [LANES*DATA_BITS-1:0] s_data1,
    input  logic [2:0]                 s_op,
    input  logic                       s_valid,
    output logic [LANES*DATA_BITS-1:0] m_data0,
    output logic [LANES*DATA_BITS-1:0] m_data1,
    output logic                       m_valid
);
    localparam int DW    = LANES*DATA_BITS;
    localparam int PW    = 2*DATA_BITS;
    localparam int DEPTH = LATENCY-1;

    localparam logic [2:0] OP_ADD    = 3'd0;
    localparam logic [2:0] OP_SUB    = 3'd1;
    localparam logic [2:0] OP_MAX    = 3'd2;
    localparam logic [2:0] OP_MIN    = 3'd3;
    localparam logic [2:0] OP_MAC    = 3'd4;
    localparam logic [2:0] OP_MACCLR = 3'd5;

`ifdef SPU_CALC_SAT_EN
    localparam bit SAT_EN = 1'b1;
`else
    localparam bit SAT_EN = 1'b0;
`endif

    function automatic logic [DATA_BITS-1:0] reduce_sum(input logic [DATA_BITS:0] v);
        logic ovf;
        ovf = SAT_EN && (v[DATA_BITS] != v[DATA_BITS-1]);
        return ovf ? {v[DATA_BITS], {(DATA_BITS-1){~v[DATA_BITS]}}} : v[DATA_BITS-1:0];
    endfunction

    // The value fits when every bit above the result sign matches it.
    function automatic logic [DATA_BITS-1:0] reduce_acc(input logic [ACC_BITS-1:0] v);
        logic [ACC_BITS-DATA_BITS:0] top;
        logic                        ovf;
        top = v[ACC_BITS-1:DATA_BITS-1];
        ovf = SAT_EN && !((&top) || !(|top));
        return ovf ? {v[ACC_BITS-1], {(DATA_BITS-1){~v[ACC_BITS-1]}}} : v[DATA_BITS-1:0];
    endfunction

    logic          s0_valid_q;
    logic [2:0]    s0_op_q;
    logic [DW-1:0] s0_a_q;
    logic [DW-1:0] s0_b_q;

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            s0_valid_q <= 1'b0;
            s0_op_q    <= '0;
            s0_a_q     <= '0;
            s0_b_q     <= '0;
        end else if (cke) begin
            s0_valid_q <= s_valid;
            s0_op_q    <= s_op;
            s0_a_q     <= s_data0;
            s0_b_q     <= s_data1;
        end
    end

    logic [DW-1:0] s1_d0_d;
    logic [DW-1:0] s1_d1_d;

    for (genvar l = 0; l < LANES; l++) begin : g_lane
        logic signed [DATA_BITS-1:0] a;
        logic signed [DATA_BITS-1:0] b;
        logic [PW-1:0]               prod;
        logic [DATA_BITS:0]          sum;
        logic [DATA_BITS:0]          diff;
        logic [ACC_BITS-1:0]         prod_ext;
        logic [ACC_BITS-1:0]         mac_sum;
        logic [ACC_BITS-1:0]         acc_q;
        logic [ACC_BITS-1:0]         acc_d;
        logic [DATA_BITS-1:0]        res;

        assign a        = s0_a_q[l*DATA_BITS +: DATA_BITS];
        assign b        = s0_b_q[l*DATA_BITS +: DATA_BITS];
        assign prod     = {{DATA_BITS{a[DATA_BITS-1]}}, a} * {{DATA_BITS{b[DATA_BITS-1]}}, b};
        assign sum      = {a[DATA_BITS-1], a} + {b[DATA_BITS-1], b};
        assign diff     = {a[DATA_BITS-1], a} - {b[DATA_BITS-1], b};
        assign prod_ext = {{(ACC_BITS-PW){prod[PW-1]}}, prod};
        assign mac_sum  = acc_q + prod_ext;

        // NOTE: defaults first so every path assigns both outputs and no latch is inferred.
        always_comb begin
            acc_d = acc_q;
            res   = '0;
            case (s0_op_q)
                OP_ADD:    res = reduce_sum(sum);
                OP_SUB:    res = reduce_sum(diff);
                OP_MAX:    res = (a > b) ? a : b;
                OP_MIN:    res = (a < b) ? a : b;
                OP_MAC: begin
                    acc_d = mac_sum;
                    res   = reduce_acc(mac_sum);
                end
                OP_MACCLR: begin
                    acc_d = prod_ext;
                    res   = reduce_acc(prod_ext);
                end
                default:   res = '0;
            endcase
        end

        // Updated the same cycle it is read, so back-to-back MACs chain without a bubble.
        always_ff @(posedge clk) begin
            if (reset) begin
                acc_q <= '0;
            end else if (cke && s0_valid_q) begin
                acc_q <= acc_d;
            end
        end

        assign s1_d0_d[l*DATA_BITS +: DATA_BITS] = prod[DATA_BITS-1:0];
        assign s1_d1_d[l*DATA_BITS +: DATA_BITS] = res;
    end

    // Index 0 is the compute stage register; the rest are plain delay.
    logic          pv_q  [DEPTH];
    logic [DW-1:0] pd0_q [DEPTH];
    logic [DW-1:0] pd1_q [DEPTH];

    // NOTE: the delay arrays are reset so no stale valid can emerge after reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int k = 0; k < DEPTH; k++) begin
                pv_q[k]  <= 1'b0;
                pd0_q[k] <= '0;
                pd1_q[k] <= '0;
            end
        end else if (cke) begin
            pv_q[0]  <= s0_valid_q;
            pd0_q[0] <= s1_d0_d;
            pd1_q[0] <= s1_d1_d;
            for (int k = 1; k < DEPTH; k++) begin
                pv_q[k]  <= pv_q[k-1];
                pd0_q[k] <= pd0_q[k-1];
                pd1_q[k] <= pd1_q[k-1];
            end
        end
    end

    assign m_valid = pv_q[DEPTH-1];
    assign m_data0 = pd0_q[DEPTH-1];
    assign m_data1 = pd1_q[DEPTH-1];
endmodule

// File: tb/tb_spu_calc_element_multi.sv
// Scoreboard bench for spu_calc_element_multi: random and directed beats checked against a lane-level arithmetic model.
module tb_spu_calc_element_multi;
    localparam int LANES = 4;
    localparam int DB    = 8;
    localparam int AB    = 2*DB+8;
    localparam int LAT   = 3;
    localparam int DW    = LANES*DB;

    logic          clk;
    logic          reset;
    logic          cke;
    logic [DW-1:0] s_data0;
    logic [DW-1:0] s_data1;
    logic [2:0]    s_op;
    logic          s_valid;
    logic [DW-1:0] m_data0;
    logic [DW-1:0] m_data1;
    logic          m_valid;

    spu_calc_element_multi #(
        .LANES(LANES), .DATA_BITS(DB), .ACC_BITS(AB), .LATENCY(LAT)
    ) dut (
        .clk(clk), .reset(reset), .cke(cke),
        .s_data0(s_data0), .s_data1(s_data1), .s_op(s_op), .s_valid(s_valid),
        .m_data0(m_data0), .m_data1(m_data1), .m_valid(m_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [DW-1:0] d0;
        logic [DW-1:0] d1;
        int            due;
    } exp_t;

    exp_t   sb_q[$];
    longint acc_m[LANES];
    int     n_checks = 0;
    int     n_fail   = 0;
    int     ke_count = 0;
    bit     cke_seen = 1'b0;
    bit     rst_seen = 1'b0;
    bit     have_prev = 1'b0;
    logic          prev_v;
    logic [DW-1:0] prev_d0;
    logic [DW-1:0] prev_d1;

    function automatic longint wrap(input longint v, input int bits);
        longint m;
        longint r;
        m = longint'(1) << bits;
        r = v % m;
        if (r < 0) r += m;
        if (r >= m/2) r -= m;
        return r;
    endfunction

    function automatic longint reduce(input longint v);
`ifdef SPU_CALC_SAT_EN
        longint hi;
        longint lo;
        hi = (longint'(1) << (DB-1)) - 1;
        lo = -(longint'(1) << (DB-1));
        return (v > hi) ? hi : ((v < lo) ? lo : v);
`else
        return wrap(v, DB);
`endif
    endfunction

    function automatic logic [DW-1:0] rep(input int v);
        logic [31:0]   t;
        logic [DW-1:0] r;
        t = v;
        for (int l = 0; l < LANES; l++) r[l*DB +: DB] = t[DB-1:0];
        return r;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic issue(input bit v, input logic [2:0] op, input logic [DW-1:0] a,
                         input logic [DW-1:0] b, input bit ck = 1'b1);
        exp_t        e;
        longint      x, y, p, r;
        logic [63:0] t;
        @(posedge clk);
        #1;
        reset   = 1'b0;
        cke     = ck;
        s_valid = v;
        s_op    = op;
        s_data0 = a;
        s_data1 = b;
        if (v && ck) begin
            for (int l = 0; l < LANES; l++) begin
                x = longint'($signed(a[l*DB +: DB]));
                y = longint'($signed(b[l*DB +: DB]));
                p = x * y;
                case (op)
                    3'd0: r = reduce(x + y);
                    3'd1: r = reduce(x - y);
                    3'd2: r = (x > y) ? x : y;
                    3'd3: r = (x < y) ? x : y;
                    3'd4: begin acc_m[l] = wrap(acc_m[l] + p, AB); r = reduce(acc_m[l]); end
                    3'd5: begin acc_m[l] = wrap(p, AB); r = reduce(acc_m[l]); end
                    default: r = 0;
                endcase
                t = p;
                e.d0[l*DB +: DB] = t[DB-1:0];
                t = r;
                e.d1[l*DB +: DB] = t[DB-1:0];
            end
            e.due = ke_count + LAT;
            sb_q.push_back(e);
        end
    endtask

    task automatic do_reset();
        exp_t keep[$];
        @(posedge clk);
        #1;
        reset   = 1'b1;
        s_valid = 1'b0;
        cke     = 1'($urandom_range(0, 1));
        foreach (sb_q[i]) if (sb_q[i].due <= ke_count) keep.push_back(sb_q[i]);
        sb_q = keep;
        for (int l = 0; l < LANES; l++) acc_m[l] = 0;
    endtask

    always @(posedge clk) begin
        cke_seen = cke;
        rst_seen = reset;
        if (cke && !reset) ke_count++;
    end

    // Monitor: consumes one expected entry per valid output produced on a cke-qualified edge.
    always @(negedge clk) begin
        exp_t e;
        if (rst_seen) begin
            check("rst_m_valid", 64'(m_valid), 64'd0);
            check("rst_m_data0", 64'(m_data0), 64'd0);
            check("rst_m_data1", 64'(m_data1), 64'd0);
            have_prev = 1'b1;
        end else if (!cke_seen) begin
            if (have_prev) begin
                check("hold_m_valid", 64'(m_valid), 64'(prev_v));
                check("hold_m_data0", 64'(m_data0), 64'(prev_d0));
                check("hold_m_data1", 64'(m_data1), 64'(prev_d1));
            end
        end else if (m_valid) begin
            if (sb_q.size() == 0) begin
                check("unexpected_valid", 64'(m_valid), 64'd0);
            end else begin
                e = sb_q.pop_front();
                check("latency", 64'(ke_count), 64'(e.due));
                check("m_data0", 64'(m_data0), 64'(e.d0));
                check("m_data1", 64'(m_data1), 64'(e.d1));
            end
        end else if (sb_q.size() != 0 && sb_q[0].due <= ke_count) begin
            check("missing_valid", 64'(m_valid), 64'd1);
            void'(sb_q.pop_front());
        end
        prev_v  = m_valid;
        prev_d0 = m_data0;
        prev_d1 = m_data1;
    end

    initial begin
        logic [DW-1:0] ai;
        reset   = 1'b1;
        cke     = 1'b0;
        s_valid = 1'b0;
        s_op    = '0;
        s_data0 = '0;
        s_data1 = '0;
        for (int l = 0; l < LANES; l++) acc_m[l] = 0;
        repeat (3) @(posedge clk);

        // Arithmetic opcodes and wrap/saturation boundaries
        issue(1, 3'd0, rep(100), rep(50));
        issue(1, 3'd1, rep(-100), rep(100));
        issue(1, 3'd2, rep(-5), rep(3));
        issue(1, 3'd3, rep(-5), rep(3));
        issue(1, 3'd0, rep(-128), rep(-128));
        issue(1, 3'd6, rep(9), rep(9));
        issue(1, 3'd7, rep(-9), rep(9));

        // Back-to-back MAC chain with an invalid beat in the middle
        issue(1, 3'd5, rep(7), rep(7));
        issue(1, 3'd4, rep(3), rep(4));
        issue(0, 3'd4, rep(100), rep(100));
        issue(1, 3'd4, rep(5), rep(6));
        issue(1, 3'd4, rep(-2), rep(10));
        issue(1, 3'd4, rep(127), rep(127));

        // Lane independence
        for (int l = 0; l < LANES; l++) ai[l*DB +: DB] = DB'(l);
        issue(1, 3'd5, ai, ai);
        issue(1, 3'd0, rep(1), rep(2));
        issue(1, 3'd4, rep(1), rep(1));

        // Stall in the middle of a 3-beat MAC stream
        issue(1, 3'd5, rep(2), rep(2));
        issue(1, 3'd4, rep(3), rep(3));
        issue(0, 3'd0, '0, '0, 0);
        issue(0, 3'd0, '0, '0, 0);
        issue(1, 3'd4, rep(-4), rep(5));
        repeat (LAT + 1) issue(0, 3'd0, '0, '0);

        // Reset with two beats in flight
        issue(1, 3'd5, rep(7), rep(7));
        repeat (LAT + 1) issue(0, 3'd0, '0, '0);
        issue(1, 3'd4, rep(1), rep(1));
        issue(1, 3'd4, rep(1), rep(1));
        do_reset();
        issue(1, 3'd4, rep(2), rep(3));
        repeat (LAT + 1) issue(0, 3'd0, '0, '0);

        // Random traffic with stalls and occasional resets
        for (int n = 0; n < 600; n++) begin
            if ($urandom_range(0, 99) == 0) begin
                do_reset();
            end else begin
                issue($urandom_range(0, 3) != 0, 3'($urandom_range(0, 7)),
                      DW'($urandom), DW'($urandom), $urandom_range(0, 4) != 0);
            end
        end

        repeat (LAT + 2) issue(0, 3'd0, '0, '0);
        @(negedge clk);
        check("drain_empty", 64'(sb_q.size()), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
